// File: rtl/cpu_pkg.sv
// Core-wide constants shared by the CDB arbiter, ROB and reservation stations.
package cpu_pkg;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int PTR_W   = $clog2(NUM_REQ);

  // Functional-unit indices into the request vectors.
  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_LSU = 2;
  localparam int FU_BR  = 3;

  typedef logic [PTR_W-1:0] fu_idx_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_picker #(
  parameter  int NUM_REQ = cpu_pkg::NUM_REQ,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   win
);

  // Scan the search order backwards so the last hit is the highest-priority one.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant = '0;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        win = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: one completed result per cycle,
// registered onto Cdb_*, with arbitration blocked for a cycle on flush or mispredict.
module cdb_arbiter #(
  parameter  int NUM_REQ = cpu_pkg::NUM_REQ,
  parameter  int TAG_W   = cpu_pkg::TAG_W,
  parameter  int DATA_W  = cpu_pkg::DATA_W,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_branch,
  input  logic [NUM_REQ-1:0]        req_branch_taken,
  output logic [NUM_REQ-1:0]        grant,
  input  logic                      flush,
  output logic                      Cdb_valid,
  output logic [TAG_W-1:0]          Cdb_rd_tag,
  output logic [DATA_W-1:0]         Cdb_data,
  output logic                      Cdb_branch,
  output logic                      Cdb_branch_taken,
  output logic [PTR_W-1:0]          Cdb_src
);

  logic [NUM_REQ-1:0] grant_raw;
  logic [PTR_W-1:0]   win;
  logic               block;
  logic               fire;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              self_flush_q, self_flush_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_rd_tag_q, cdb_rd_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_branch_q, cdb_branch_d;
  logic              cdb_branch_taken_q, cdb_branch_taken_d;
  logic [PTR_W-1:0]  cdb_src_q, cdb_src_d;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant_raw),
    .win   (win)
  );

  // A taken branch on the CDB blocks the next arbitration so wrong-path results
  // cannot slip onto the bus while the ROB flush propagates.
  assign block = reset | flush | self_flush_q;
  assign grant = block ? '0 : grant_raw;
  assign fire  = |grant;

  always_comb begin
    ptr_d              = ptr_q;
    self_flush_d       = 1'b0;
    cdb_valid_d        = fire;
    cdb_rd_tag_d       = cdb_rd_tag_q;
    cdb_data_d         = cdb_data_q;
    cdb_branch_d       = cdb_branch_q;
    cdb_branch_taken_d = cdb_branch_taken_q;
    cdb_src_d          = cdb_src_q;
    if (fire) begin
      ptr_d              = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
      self_flush_d       = req_branch[win] & req_branch_taken[win];
      cdb_rd_tag_d       = req_tag[int'(win) * TAG_W +: TAG_W];
      cdb_data_d         = req_data[int'(win) * DATA_W +: DATA_W];
      cdb_branch_d       = req_branch[win];
      cdb_branch_taken_d = req_branch_taken[win];
      cdb_src_d          = win;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q              <= '0;
      self_flush_q       <= 1'b0;
      cdb_valid_q        <= 1'b0;
      cdb_rd_tag_q       <= '0;
      cdb_data_q         <= '0;
      cdb_branch_q       <= 1'b0;
      cdb_branch_taken_q <= 1'b0;
      cdb_src_q          <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      ptr_q              <= ptr_d;
      self_flush_q       <= self_flush_d;
      cdb_valid_q        <= cdb_valid_d;
      cdb_rd_tag_q       <= cdb_rd_tag_d;
      cdb_data_q         <= cdb_data_d;
      cdb_branch_q       <= cdb_branch_d;
      cdb_branch_taken_q <= cdb_branch_taken_d;
      cdb_src_q          <= cdb_src_d;
    end
  end

  assign Cdb_valid        = cdb_valid_q;
  assign Cdb_rd_tag       = cdb_rd_tag_q;
  assign Cdb_data         = cdb_data_q;
  assign Cdb_branch       = cdb_branch_q;
  assign Cdb_branch_taken = cdb_branch_taken_q;
  assign Cdb_src          = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then randomized traffic
// against a unit-level round-robin reference model.
module tb_cdb_arbiter;
  import cpu_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_branch;
  logic [NUM_REQ-1:0]        req_branch_taken;
  logic [NUM_REQ-1:0]        grant;
  logic                      flush;
  logic                      Cdb_valid;
  logic [TAG_W-1:0]          Cdb_rd_tag;
  logic [DATA_W-1:0]         Cdb_data;
  logic                      Cdb_branch;
  logic                      Cdb_branch_taken;
  logic [PTR_W-1:0]          Cdb_src;

  cdb_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .req              (req),
    .req_tag          (req_tag),
    .req_data         (req_data),
    .req_branch       (req_branch),
    .req_branch_taken (req_branch_taken),
    .grant            (grant),
    .flush            (flush),
    .Cdb_valid        (Cdb_valid),
    .Cdb_rd_tag       (Cdb_rd_tag),
    .Cdb_data         (Cdb_data),
    .Cdb_branch       (Cdb_branch),
    .Cdb_branch_taken (Cdb_branch_taken),
    .Cdb_src          (Cdb_src)
  );

  always #5 clock = ~clock;

  typedef struct {
    int                cyc;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              br;
    logic              tk;
    logic [PTR_W-1:0]  src;
  } cdb_t;

  int   vectors   = 0;
  int   miscompares = 0;
  int   cycle     = 0;
  cdb_t exp_q[$];
  cdb_t last;

  // Unit-side view: each unit holds its result until granted.
  bit                u_req[NUM_REQ];
  logic [TAG_W-1:0]  u_tag[NUM_REQ];
  logic [DATA_W-1:0] u_data[NUM_REQ];
  bit                u_br[NUM_REQ];
  bit                u_tk[NUM_REQ];

  // Reference model: rotating priority start and a one-cycle post-mispredict block.
  int ptr_m = 0;
  bit blk_m = 0;

  always @(posedge clock) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic drive(input bit fl);
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i]                       = u_req[i];
      req_tag[i*TAG_W +: TAG_W]    = u_tag[i];
      req_data[i*DATA_W +: DATA_W] = u_data[i];
      req_branch[i]                = u_br[i];
      req_branch_taken[i]          = u_tk[i];
    end
    flush = fl;
  endtask

  task automatic set_unit(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                          input bit br, input bit tk);
    u_req[i] = 1'b1; u_tag[i] = t; u_data[i] = d; u_br[i] = br; u_tk[i] = tk;
  endtask

  // One arbitration cycle: predict the winner, check grant, queue the CDB result.
  task automatic step(input bit fl);
    int            w;
    logic [NUM_REQ-1:0] exp_g;
    cdb_t          e;
    drive(fl);
    #1;
    w = -1;
    if (!fl && !blk_m)
      for (int k = 0; k < NUM_REQ; k++)
        if (w < 0 && u_req[(ptr_m + k) % NUM_REQ]) w = (ptr_m + k) % NUM_REQ;
    exp_g = (w >= 0) ? NUM_REQ'(1 << w) : '0;
    check("grant", grant, exp_g);
    if (w >= 0) begin
      e.cyc = cycle + 1; e.tag = u_tag[w]; e.data = u_data[w];
      e.br = u_br[w]; e.tk = u_tk[w]; e.src = PTR_W'(w);
      exp_q.push_back(e);
    end
    @(posedge clock);
    if (w >= 0) begin
      ptr_m = (w + 1) % NUM_REQ;
      blk_m = u_br[w] && u_tk[w];
      u_req[w] = 1'b0;
    end else begin
      blk_m = 1'b0;
    end
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_valid"}, Cdb_valid, 0);
    check({tag, "_rd_tag"}, Cdb_rd_tag, 0);
    check({tag, "_data"}, Cdb_data, 0);
    check({tag, "_branch"}, Cdb_branch, 0);
    check({tag, "_taken"}, Cdb_branch_taken, 0);
    check({tag, "_src"}, Cdb_src, 0);
  endtask

  // Asynchronous reset mid-cycle, released between edges, then arbitration resumes.
  task automatic reset_mid();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    last  = '{default: '0};
    ptr_m = 0;
    blk_m = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    step(1'b0);
  endtask

  // Monitor: one comparison set per cycle, independent of stimulus.
  initial begin
    last = '{default: '0};
    forever begin
      @(negedge clock);
      if (!reset) begin
        bit vld;
        vld = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
          last = exp_q.pop_front();
          vld  = 1'b1;
        end
        check("cdb_valid", Cdb_valid, vld);
        check("cdb_rd_tag", Cdb_rd_tag, last.tag);
        check("cdb_data", Cdb_data, last.data);
        check("cdb_branch", Cdb_branch, last.br);
        check("cdb_taken", Cdb_branch_taken, last.tk);
        check("cdb_src", Cdb_src, last.src);
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      u_req[i] = 0; u_tag[i] = '0; u_data[i] = '0; u_br[i] = 0; u_tk[i] = 0;
    end
    reset = 1'b1;
    drive(1'b0);
    #1;
    check_zero("reset");
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Single uncontended request.
    set_unit(FU_ALU, 5'd7, 32'hDEADBEEF, 0, 0);
    step(0);
    step(0);

    // Move ptr back to 0, then all four contend.
    set_unit(FU_BR, 5'd3, 32'h0000_0033, 0, 0);
    step(0);
    for (int i = 0; i < NUM_REQ; i++) set_unit(i, TAG_W'(10 + i), 32'hA000_0000 + i, 0, 0);
    repeat (4) step(0);

    // Wrap-around with units 1 and 3.
    set_unit(FU_MUL, 5'd17, 32'h1111_1111, 0, 0);
    set_unit(FU_BR, 5'd19, 32'h3333_3333, 0, 0);
    repeat (2) step(0);

    // Mispredict: park ptr at 3, then a taken branch with ALU waiting.
    set_unit(FU_LSU, 5'd2, 32'h2222_2222, 0, 0);
    step(0);
    set_unit(FU_BR, 5'd21, 32'hB0B0_B0B0, 1, 1);
    set_unit(FU_ALU, 5'd22, 32'hA1A1_A1A1, 0, 0);
    repeat (3) step(0);

    // External flush with units 1 and 2 pending.
    set_unit(FU_MUL, 5'd5, 32'h5555_0001, 0, 0);
    set_unit(FU_LSU, 5'd6, 32'h6666_0002, 0, 0);
    step(1);
    repeat (2) step(0);

    // Reset while the CDB is valid and requests are pending.
    for (int i = 0; i < NUM_REQ; i++) set_unit(i, TAG_W'(24 + i), 32'hC000_0000 + i, 0, 0);
    step(0);
    reset_mid();
    repeat (3) step(0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!u_req[i] && ($urandom_range(1, 0) == 1)) begin
          bit br;
          br = (i == FU_BR);
          set_unit(i, TAG_W'($urandom), $urandom, br, br && ($urandom_range(3, 0) == 0));
        end
      if ($urandom_range(99, 0) == 0) reset_mid();
      else step($urandom_range(15, 0) == 0);
    end

    for (int i = 0; i < NUM_REQ; i++) u_req[i] = 0;
    repeat (2) step(0);
    @(negedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) among the functional-unit completion ports (ALU, multiplier, load/store, branch). It grants at most one completed result per cycle and drives the registered Cdb_* signals consumed by the ROB, reservation stations and register-status logic. It also squashes in-flight grants when the pipeline flushes.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting functional units (index 0=ALU, 1=MUL, 2=LSU, 3=BR)
- TAG_W, 5, ROB tag width
- DATA_W, 32, result data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-unit result-valid request
- req_tag  in  NUM_REQ*TAG_W  per-unit ROB tag, unit i at [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  per-unit result, unit i at [i*DATA_W +: DATA_W]
- req_branch  in  NUM_REQ  result belongs to a branch
- req_branch_taken  in  NUM_REQ  branch resolved taken (mispredict)
- grant  out  NUM_REQ  one-hot acknowledge; unit i's result is accepted this cycle
- flush  in  1  pipeline flush; squashes arbitration this cycle
- Cdb_valid  out  1  CDB carries a result
- Cdb_rd_tag  out  TAG_W  tag on CDB
- Cdb_data  out  DATA_W  data on CDB
- Cdb_branch  out  1  CDB result is a branch
- Cdb_branch_taken  out  1  CDB branch taken
- Cdb_src  out  2  index of the unit driving the CDB, debug/verification only

## Operation
- Handshake: a unit raises req[i] with stable tag/data/branch fields and holds them until it sees grant[i]=1 at a rising edge. The transfer completes on that edge. The unit may drop or replace its request only after the grant.
- grant is combinational from req, the priority pointer and flush. It is one-hot or zero, and never set for a unit whose req[i]=0.
- Priority: round-robin pointer ptr (2 bits). Search order is ptr, ptr+1, …, ptr+NUM_REQ-1, mod NUM_REQ; the first requesting index wins.
- Pointer update: on a grant to unit w, ptr becomes (w+1) mod NUM_REQ, wrapping 3 to 0. With no grant, ptr holds.
- CDB register: on a grant, Cdb_* load the winner's fields, Cdb_valid=1 and Cdb_src=w. With no grant, Cdb_valid=0 and the other Cdb_* fields hold their previous values.
- Flush: while flush=1, grant=0 and ptr holds. On the next edge, Cdb_valid=0. This cancels nothing already on the CDB, since a result presented this cycle has already been seen by consumers.
- Self-flush: when Cdb_valid & Cdb_branch & Cdb_branch_taken is registered, grant is forced to 0 for the following cycle. This stops wrong-path results from reaching the CDB while the ROB flush propagates. It has the same effect as flush.
- Reset: ptr=0, Cdb_valid=0, Cdb_rd_tag=0, Cdb_data=0, Cdb_branch=0, Cdb_branch_taken=0, Cdb_src=0, grant=0. Reset asserted mid-transfer discards the pending grant; the unit's held request re-arbitrates after release.

## Timing
- Latency: request to Cdb_valid is 1 cycle when uncontended. Under contention, worst-case wait is NUM_REQ-1 grants (3 cycles), with no starvation.
- Throughput: 1 result per cycle. Back-to-back grants to different units produce consecutive Cdb_valid cycles.
- A single unit requesting continuously is granted every cycle.
- flush and the self-flush block exactly one arbitration cycle each. If both occur in the same cycle, still only one cycle is blocked.

## Structure
- Shared package cpu_pkg holds TAG_W, DATA_W, NUM_REQ and the FU index constants FU_ALU=0, FU_MUL=1, FU_LSU=2, FU_BR=3. The ROB and reservation stations use the same constants.
- Sub-module rr_picker: purely combinational. Inputs are req and ptr; outputs are the one-hot grant and the encoded winner index.
- The top level holds ptr, the CDB output register, the self-flush register and the field mux.

## Test plan
- After reset, only req[0]=1 with tag=5'd7, data=32'hDEADBEEF gives grant[0]=1 that cycle. The next cycle shows Cdb_valid=1, Cdb_rd_tag=7, Cdb_data=32'hDEADBEEF, Cdb_src=0, then Cdb_valid=0.
- All four units request together from ptr=0 and hold until granted. Expected grants are 0,1,2,3 on consecutive cycles, with four consecutive Cdb_valid cycles whose Cdb_src is 0,1,2,3.
- Wrap-around: after granting unit 3 (ptr=0), req[1] and req[3] are both asserted. Expected grants are unit 1, then unit 3; ptr ends at 0.
- Mispredict: unit 3 is granted with branch=1, taken=1 while req[0] is held. Cdb_branch_taken=1 is followed by one cycle with grant=0, and unit 0 is granted the cycle after.
- flush=1 for one cycle with req=4'b0110. That cycle has grant=0, the next Cdb_valid=0 and ptr is unchanged. The following cycle grants unit 1.
- Assert reset while Cdb_valid=1 and requests are pending. All outputs go to zero immediately. After release, arbitration restarts at ptr=0.
